gcd_feeder: RTL



---
 rtl/gcd_feeder.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/gcd_feeder.sv
// gcd_feeder: job sequencer around a multi-cycle gcd engine.
// Buffers operand pairs in a DEPTH-entry FIFO, launches one engine job at a time with a
// single-cycle gcd_start pulse, captures the result into a valid/ready output register and
// releases the engine with a single-cycle gcd_res_fetch pulse.
// Optional feature: define GCD_FEEDER_ZERO_BYPASS_EN to resolve jobs with a zero operand
// locally (result a | b) without involving the engine.
module gcd_feeder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             busy,
  output logic [WIDTH-1:0] gcd_a,
  output logic [WIDTH-1:0] gcd_b,
  output logic             gcd_start,
  input  logic             gcd_res_rdy,
  input  logic [WIDTH-1:0] gcd_res,
  output logic             gcd_res_fetch
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StStart, StWait, StFetch} state_e;

  state_e state_q, state_d;

  // FIFO storage and pointers; the extra MSB of each pointer is the wrap bit
  logic [WIDTH-1:0] mem_a_q [DEPTH];
  logic [WIDTH-1:0] mem_b_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             full, empty, push, pop;
  logic [WIDTH-1:0] head_a, head_b;

  // Engine operand and output registers
  logic [WIDTH-1:0] gcd_a_q, gcd_b_q;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_res_q, out_res_d;

  // FSM decisions
  logic out_free;   // output register empty or draining this cycle
  logic byp_head;   // head entry qualifies for local resolution
  logic launch;     // pop head and send it to the engine
  logic bypass;     // pop head and resolve it locally
  logic load_eng;   // capture engine result into the output register

  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push   = in_valid && !full;
  assign pop    = launch || bypass;
  assign head_a = mem_a_q[rd_ptr_q[AW-1:0]];
  assign head_b = mem_b_q[rd_ptr_q[AW-1:0]];

  assign out_free = !out_valid_q || out_ready;

`ifdef GCD_FEEDER_ZERO_BYPASS_EN
  assign byp_head = (head_a == '0) || (head_b == '0);
`else
  assign byp_head = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state and pop/load decisions
  always_comb begin
    state_d  = state_q;
    launch   = 1'b0;
    bypass   = 1'b0;
    load_eng = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty && byp_head) begin
          // A zero-operand head never goes to the engine; it waits for output space
          bypass = out_free;
        end else if (!empty && !gcd_res_rdy) begin
          launch  = 1'b1;
          state_d = StStart;
        end
      end
      StStart: begin
        state_d = StWait;
      end
      StWait: begin
        // Leaving the engine holding its result is the backpressure path
        if (gcd_res_rdy && out_free) begin
          load_eng = 1'b1;
          state_d  = StFetch;
        end
      end
      StFetch: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM-decoded outputs and status
  always_comb begin
    gcd_start     = (state_q == StStart);
    gcd_res_fetch = (state_q == StFetch);
    in_ready      = !full;
    busy          = (state_q != StIdle) || !empty || out_valid_q;
  end

  // FIFO pointers; reset flushes the queue
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
    end
  end

  // FIFO storage write; contents need no reset since the pointers gate visibility
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a_q[wr_ptr_q[AW-1:0]] <= in_a;
      mem_b_q[wr_ptr_q[AW-1:0]] <= in_b;
    end
  end

  // Engine operands: captured on launch, held until the next launch
  always_ff @(posedge clk) begin
    if (rst) begin
      gcd_a_q <= '0;
      gcd_b_q <= '0;
    end else if (launch) begin
      gcd_a_q <= head_a;
      gcd_b_q <= head_b;
    end
  end

  // Output register next state; a load wins over a simultaneous drain
  always_comb begin
    out_res_d   = out_res_q;
    out_valid_d = out_valid_q;
    if (bypass) begin
      out_res_d   = head_a | head_b;
      out_valid_d = 1'b1;
    end else if (load_eng) begin
      out_res_d   = gcd_res;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_res_q   <= out_res_d;
    end
  end

  assign gcd_a     = gcd_a_q;
  assign gcd_b     = gcd_b_q;
  assign out_valid = out_valid_q;
  assign out_res   = out_res_q;

endmodule
